// File: rtl/lut_config_writer.sv
// lut_config_writer: serialises configuration words bit by bit onto a cluster's shared LUTRAM write port.
// Define LUT_CFG_READBACK_EN to add a per-LUT readback verify sweep and a sticky cfg_error flag.
module lut_config_writer #(
  parameter int ZUMA_LUT_SIZE = 6,
  parameter int NUM_LUTS = 8,
  parameter int WORD_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [WORD_W-1:0]        cfg_data,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  output logic [ZUMA_LUT_SIZE-1:0] lut_a,
  output logic                     lut_d,
  output logic [NUM_LUTS-1:0]      lut_we,
`ifdef LUT_CFG_READBACK_EN
  output logic [ZUMA_LUT_SIZE-1:0] lut_dpra,
  input  logic [NUM_LUTS-1:0]      lut_dpo,
  output logic                     cfg_error,
`endif
  output logic                     busy,
  output logic                     done
);
  localparam int DEPTH = 1 << ZUMA_LUT_SIZE;
  localparam int LIW = NUM_LUTS > 1 ? $clog2(NUM_LUTS) : 1;
  localparam int WBW = WORD_W > 1 ? $clog2(WORD_W) : 1;
  localparam int VW = ZUMA_LUT_SIZE + 1;
  typedef enum logic [2:0] {
    IDLE, LOAD, SHIFT,
`ifdef LUT_CFG_READBACK_EN
    VERIFY,
`endif
    DONE
  } state_t;
  state_t state_q, state_d;
  logic [ZUMA_LUT_SIZE-1:0] bit_addr_q, bit_addr_d, lut_a_q, lut_a_d;
  logic [LIW-1:0] lut_idx_q, lut_idx_d;
  logic [WBW-1:0] word_bit_q, word_bit_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [NUM_LUTS-1:0] lut_we_q, lut_we_d;
  logic cfg_ready_q, cfg_ready_d, lut_d_q, lut_d_d, busy_q, busy_d, done_q, done_d;
  logic last_bit, last_lut, word_end;
`ifdef LUT_CFG_READBACK_EN
  logic [DEPTH-1:0] shadow_q, shadow_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [ZUMA_LUT_SIZE-1:0] lut_dpra_q, lut_dpra_d, rd_idx;
  logic error_q, error_d;
`endif
  always_comb begin
    state_d = state_q;
    bit_addr_d = bit_addr_q;
    lut_idx_d = lut_idx_q;
    word_bit_d = word_bit_q;
    shreg_d = shreg_q;
    last_bit = bit_addr_q == ZUMA_LUT_SIZE'(DEPTH - 1);
    last_lut = lut_idx_q == LIW'(NUM_LUTS - 1);
    word_end = word_bit_q == WBW'(WORD_W - 1);
`ifdef LUT_CFG_READBACK_EN
    shadow_d = shadow_q;
    vcnt_d = vcnt_q;
    error_d = error_q;
    rd_idx = ZUMA_LUT_SIZE'(vcnt_q - VW'(1));
`endif
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = LOAD;
        bit_addr_d = '0;
        lut_idx_d = '0;
        word_bit_d = '0;
        shreg_d = '0;
`ifdef LUT_CFG_READBACK_EN
        vcnt_d = '0;
        error_d = 1'b0;
`endif
      end
      LOAD: if (cfg_valid && cfg_ready_q) begin
        state_d = SHIFT;
        shreg_d = cfg_data;
      end
      SHIFT: begin
        shreg_d = shreg_q >> 1;
        bit_addr_d = bit_addr_q + ZUMA_LUT_SIZE'(1);
        word_bit_d = word_bit_q + WBW'(1);
`ifdef LUT_CFG_READBACK_EN
        shadow_d[bit_addr_q] = shreg_q[0];
        if (word_end) state_d = last_bit ? VERIFY : LOAD;
`else
        if (last_bit) lut_idx_d = last_lut ? '0 : lut_idx_q + LIW'(1);
        if (word_end) state_d = (last_bit && last_lut) ? DONE : LOAD;
`endif
      end
`ifdef LUT_CFG_READBACK_EN
      // Read data lags the presented address by one cycle, hence the extra sweep cycle.
      VERIFY: begin
        vcnt_d = vcnt_q + VW'(1);
        if (vcnt_q != '0 && lut_dpo[lut_idx_q] != shadow_q[rd_idx]) error_d = 1'b1;
        if (vcnt_q == VW'(DEPTH)) begin
          vcnt_d = '0;
          state_d = last_lut ? DONE : LOAD;
          lut_idx_d = last_lut ? '0 : lut_idx_q + LIW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    cfg_ready_d = state_d == LOAD;
    lut_we_d = state_d == SHIFT ? NUM_LUTS'(1) << lut_idx_d : '0;
    lut_a_d = bit_addr_d;
    lut_d_d = shreg_d[0];
    busy_d = state_d != IDLE && state_d != DONE;
    done_d = state_d == DONE;
`ifdef LUT_CFG_READBACK_EN
    lut_dpra_d = vcnt_d[ZUMA_LUT_SIZE-1:0];
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      bit_addr_q <= '0;
      lut_idx_q <= '0;
      word_bit_q <= '0;
      shreg_q <= '0;
      cfg_ready_q <= 1'b0;
      lut_we_q <= '0;
      lut_a_q <= '0;
      lut_d_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef LUT_CFG_READBACK_EN
      shadow_q <= '0;
      vcnt_q <= '0;
      lut_dpra_q <= '0;
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bit_addr_q <= bit_addr_d;
      lut_idx_q <= lut_idx_d;
      word_bit_q <= word_bit_d;
      shreg_q <= shreg_d;
      cfg_ready_q <= cfg_ready_d;
      lut_we_q <= lut_we_d;
      lut_a_q <= lut_a_d;
      lut_d_q <= lut_d_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef LUT_CFG_READBACK_EN
      shadow_q <= shadow_d;
      vcnt_q <= vcnt_d;
      lut_dpra_q <= lut_dpra_d;
      error_q <= error_d;
`endif
    end
  assign cfg_ready = cfg_ready_q;
  assign lut_we = lut_we_q;
  assign lut_a = lut_a_q;
  assign lut_d = lut_d_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef LUT_CFG_READBACK_EN
  assign lut_dpra = lut_dpra_q;
  assign cfg_error = error_q;
`endif
endmodule
